// File: rtl/sync_fifo_flagged_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_flagged_if                                   |
// | Description : Push/pop/status bundle for sync_fifo_flagged. The      |
// |               master side is the producer/consumer logic; the slave  |
// |               side is the FIFO. max_count exists only when           |
// |               FIFO_HWM_EN is defined.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface sync_fifo_flagged_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_HWM_EN
    logic [ADDR_WIDTH:0]   max_count;

    modport master (
        output flush, push, push_data, pop,
        input  pop_data, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow, max_count
    );

    modport slave (
        input  flush, push, push_data, pop,
        output pop_data, full, empty, almost_full, almost_empty,
        output count, overflow, underflow, max_count
    );
`else
    modport master (
        output flush, push, push_data, pop,
        input  pop_data, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  flush, push, push_data, pop,
        output pop_data, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flagged.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_flagged                                      |
// | Description : Single-clock first-word-fall-through FIFO with fill    |
// |               count, almost-full/almost-empty flags, synchronous     |
// |               flush and sticky overflow/underflow flags.             |
// |               Optional macro FIFO_HWM_EN adds a high-water-mark      |
// |               register on bus.max_count.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 1
) (
    input wire                 clk,
    input wire                 rst,
    sync_fifo_flagged_if.slave bus
);
    localparam int                  c_depth    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_af_level = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_ae_level = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_ram [c_depth];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] r_wptr;
    logic [ADDR_WIDTH:0] r_rptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_almost_full;
    logic                r_almost_empty;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_push_en;
    logic                w_pop_en;
    logic [ADDR_WIDTH:0] w_wptr_next;
    logic [ADDR_WIDTH:0] w_rptr_next;
    logic [ADDR_WIDTH:0] w_count_next;

    // Accept decisions use the flags registered at the start of the cycle.
    always_comb begin
        w_push_en    = bus.push & ~r_full;
        w_pop_en     = bus.pop & ~r_empty;
        w_wptr_next  = r_wptr + (ADDR_WIDTH + 1)'(w_push_en);
        w_rptr_next  = r_rptr + (ADDR_WIDTH + 1)'(w_pop_en);
        w_count_next = r_count + (ADDR_WIDTH + 1)'(w_push_en)
                               - (ADDR_WIDTH + 1)'(w_pop_en);
    end

    // Pointer, count and flag state; flags derive from next-state values so
    // they always agree with count. Flush outranks push/pop and error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (bus.flush) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wptr         <= w_wptr_next;
            r_rptr         <= w_rptr_next;
            r_count        <= w_count_next;
            r_full         <= (w_wptr_next[ADDR_WIDTH-1:0] == w_rptr_next[ADDR_WIDTH-1:0])
                           && (w_wptr_next[ADDR_WIDTH] != w_rptr_next[ADDR_WIDTH]);
            r_empty        <= (w_wptr_next == w_rptr_next);
            r_almost_full  <= (w_count_next >= c_af_level);
            r_almost_empty <= (w_count_next <= c_ae_level);
            if (bus.push && r_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage array has no reset; contents are meaningless after rst/flush.
    always_ff @(posedge clk) begin
        if (w_push_en && !bus.flush) begin
            r_ram[r_wptr[ADDR_WIDTH-1:0]] <= bus.push_data;
        end
    end

    assign bus.pop_data     = r_ram[r_rptr[ADDR_WIDTH-1:0]];
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

`ifdef FIFO_HWM_EN
    logic [ADDR_WIDTH:0] r_max_count;

    // High-water mark of the fill level since the last rst or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_count <= '0;
        end else if (bus.flush) begin
            r_max_count <= '0;
        end else if (w_count_next > r_max_count) begin
            r_max_count <= w_count_next;
        end
    end

    assign bus.max_count = r_max_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flagged.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sync_fifo_flagged                                   |
// | Description : Scoreboard bench for sync_fifo_flagged (8x8, AF=6,     |
// |               AE=1). Checks max_count when FIFO_HWM_EN is defined.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sync_fifo_flagged;
    localparam int c_dw    = 8;
    localparam int c_aw    = 3;
    localparam int c_depth = 8;

    logic clk;
    logic rst;

    sync_fifo_flagged_if #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw)) bus ();

    sync_fifo_flagged #(
        .DATA_WIDTH (c_dw),
        .ADDR_WIDTH (c_aw),
        .AF_LEVEL   (6),
        .AE_LEVEL   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state: queue of expected words plus modelled sticky flags.
    logic [c_dw-1:0] q [$];
    bit              m_ovf;
    bit              m_unf;
    int              m_max;
    int              n_tests;
    int              n_fail;

    // Drive one cycle of stimulus, advance the model, clock, then settle #1.
    // obs/exp/got report the head word seen before the edge when a pop is
    // accepted by the model.
    task automatic step(input bit p, input logic [c_dw-1:0] d, input bit o,
                        input bit f, output logic [c_dw-1:0] obs,
                        output logic [c_dw-1:0] exp, output bit got);
        bit was_full;
        bit was_empty;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = o;
        bus.flush     = f;
        got           = 1'b0;
        exp           = '0;
        obs           = bus.pop_data;
        was_full      = (q.size() == c_depth);
        was_empty     = (q.size() == 0);
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_max = 0;
        end else begin
            if (o && !was_empty) begin
                exp = q.pop_front();
                got = 1'b1;
            end
            if (o && was_empty) m_unf = 1'b1;
            if (p && !was_full) q.push_back(d);
            if (p && was_full) m_ovf = 1'b1;
            if (q.size() > m_max) m_max = q.size();
        end
        @(posedge clk);
        #1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.flush     = 1'b0;
        bus.push_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b want 0 1 0 1 0 0 0",
                     bus.count, bus.empty, bus.full, bus.almost_empty,
                     bus.almost_full, bus.overflow, bus.underflow);
        end
`ifdef FIFO_HWM_EN
        n_tests++;
        if (bus.max_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_max_count got=%0d want=0", bus.max_count);
        end
`endif
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;
    endtask

    task automatic test_fill_drain();
        logic [c_dw-1:0] obs, exp;
        bit got;
        for (int i = 1; i <= c_depth; i++) begin
            step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, obs, exp, got);
            n_tests++;
            if (bus.count !== 4'(i) || bus.full !== (i == c_depth) ||
                bus.almost_full !== (i >= 6) || bus.almost_empty !== (i <= 1) ||
                bus.empty !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_flags i=%0d cnt=%0d f=%b af=%b ae=%b e=%b",
                         i, bus.count, bus.full, bus.almost_full,
                         bus.almost_empty, bus.empty);
            end
        end
`ifdef FIFO_HWM_EN
        n_tests++;
        if (bus.max_count !== 4'(m_max)) begin
            n_fail++;
            $display("FAIL hwm_after_fill got=%0d want=%0d", bus.max_count, m_max);
        end
`endif
        for (int i = 0; i < c_depth; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, obs, exp, got);
            if (got) begin
                n_tests++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL drain_data i=%0d got=%h want=%h", i, obs, exp);
                end
            end
        end
        n_tests++;
        if (bus.empty !== 1'b1 || bus.count !== 4'd0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_empty e=%b cnt=%0d want e=1 cnt=0", bus.empty, bus.count);
        end
    endtask

    task automatic test_overflow();
        logic [c_dw-1:0] obs, exp;
        bit got;
        for (int i = 0; i < c_depth; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, obs, exp, got);
        step(1'b1, 8'h99, 1'b0, 1'b0, obs, exp, got);
        n_tests++;
        if (bus.overflow !== m_ovf || bus.count !== 4'd8 || bus.full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set ov=%b cnt=%0d f=%b want 1 8 1",
                     bus.overflow, bus.count, bus.full);
        end
        // Full with push+pop: pop accepted, push refused.
        step(1'b1, 8'h77, 1'b1, 1'b0, obs, exp, got);
        n_tests++;
        if (!got || obs !== exp || bus.count !== 4'(q.size())) begin
            n_fail++;
            $display("FAIL full_push_pop data=%h want=%h cnt=%0d want=%0d",
                     obs, exp, bus.count, q.size());
        end
        while (q.size() > 0) begin
            step(1'b0, '0, 1'b1, 1'b0, obs, exp, got);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL overflow_drain got=%h want=%h", obs, exp);
            end
        end
        n_tests++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky got=%b want=1", bus.overflow);
        end
        step(1'b0, '0, 1'b0, 1'b1, obs, exp, got);
        n_tests++;
        if (bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_flush got=%b want=0", bus.overflow);
        end
    endtask

    task automatic test_underflow();
        logic [c_dw-1:0] obs, exp;
        bit got;
        step(1'b0, '0, 1'b1, 1'b0, obs, exp, got);
        n_tests++;
        if (bus.underflow !== m_unf || bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_set un=%b cnt=%0d e=%b want 1 0 1",
                     bus.underflow, bus.count, bus.empty);
        end
        step(1'b0, '0, 1'b0, 1'b1, obs, exp, got);
        step(1'b1, 8'h5A, 1'b1, 1'b0, obs, exp, got);
        n_tests++;
        if (bus.count !== 4'd1 || bus.pop_data !== 8'h5A || bus.underflow !== 1'b1 ||
            bus.empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_push_pop cnt=%0d data=%h un=%b e=%b want 1 5a 1 0",
                     bus.count, bus.pop_data, bus.underflow, bus.empty);
        end
        step(1'b0, '0, 1'b0, 1'b1, obs, exp, got);
    endtask

    task automatic test_back_to_back();
        logic [c_dw-1:0] obs, exp;
        bit got;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, obs, exp, got);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, obs, exp, got);
            n_tests++;
            if (!got || obs !== exp || bus.count !== 4'd4) begin
                n_fail++;
                $display("FAIL b2b i=%0d data=%h want=%h cnt=%0d want=4",
                         i, obs, exp, bus.count);
            end
        end
        while (q.size() > 0) begin
            step(1'b0, '0, 1'b1, 1'b0, obs, exp, got);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b_drain got=%h want=%h", obs, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [c_dw-1:0] obs, exp;
        bit got;
        step(1'b0, '0, 1'b1, 1'b0, obs, exp, got);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, obs, exp, got);
        step(1'b1, 8'hEE, 1'b0, 1'b1, obs, exp, got);
        n_tests++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1 ||
            bus.almost_full !== 1'b0 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state cnt=%0d e=%b ae=%b af=%b un=%b ov=%b want 0 1 1 0 0 0",
                     bus.count, bus.empty, bus.almost_empty, bus.almost_full,
                     bus.underflow, bus.overflow);
        end
`ifdef FIFO_HWM_EN
        n_tests++;
        if (bus.max_count !== 4'd0) begin
            n_fail++;
            $display("FAIL hwm_after_flush got=%0d want=0", bus.max_count);
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [c_dw-1:0] obs, exp;
        bit got;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, obs, exp, got);
        step(1'b0, '0, 1'b1, 1'b0, obs, exp, got);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.almost_empty !== 1'b1 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset cnt=%0d e=%b f=%b ae=%b un=%b want 0 1 0 1 0",
                     bus.count, bus.empty, bus.full, bus.almost_empty, bus.underflow);
        end
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;
        @(posedge clk);
        #1;
        step(1'b1, 8'h6B, 1'b0, 1'b0, obs, exp, got);
        step(1'b0, '0, 1'b1, 1'b0, obs, exp, got);
        n_tests++;
        if (!got || obs !== exp || bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_data got=%h want=%h e=%b", obs, exp, bus.empty);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends even if a task stalls.
    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end
endmodule
`default_nettype wire
